fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline boundary of the RV32I core. It owns the PC register and drives the synchronous-read instruction memory. It presents the fetched instruction, its PC and the immediate-format selector (imm_type) to the decode stage, where the immediate generator consumes them. It supports decode stalls, control-flow redirects that squash the in-flight fetch, and holds the instruction stable across stalls.

Parameters:
RESET_PC, 32'h4000_0000, PC value loaded on reset (BIOS base).
NOP_INST, 32'h0000_0013, instruction presented on id_inst whenever id_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept; hold PC and IF/ID contents
redirect_valid  input  1  branch/jump taken; load redirect_target into PC and squash in-flight fetch
redirect_target  input  32  new PC on redirect; bits [1:0] ignored, forced to 0
imem_addr  output  32  instruction memory byte address (= pc_reg)
imem_en  output  1  instruction memory read enable
imem_rdata  input  32  instruction memory data; valid one cycle after the address/enable cycle
id_inst  output  32  instruction in decode
id_pc  output  32  PC of id_inst
id_valid  output  1  id_inst is a live instruction
id_imm_type  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
id_illegal  output  1  id_inst opcode not in RV32I set (only when id_valid=1)

Behaviour:
- Reset (rst=1 at edge): pc_reg<=RESET_PC, id_valid<=0, id_pc<=0, held<=0, hold_inst<=0. While rst=1: imem_en=0. Combinationally, id_inst=NOP_INST, id_imm_type=000, id_illegal=0.
- imem_en = !rst && (!stall || redirect_valid). imem_addr = pc_reg, with bits [1:0] always 0.
- PC update priority: rst > redirect_valid > stall > advance.
  - redirect: pc_reg<={redirect_target[31:2],2'b00}.
  - stall: hold.
  - else: pc_reg<=pc_reg+4, wrapping modulo 2^32.
- IF/ID update, same priority:
  - redirect: id_valid<=0, held<=0. Redirect squashes regardless of stall.
  - stall and !held: hold_inst<=imem_rdata, held<=1. id_pc and id_valid hold.
  - stall and held: all hold.
  - advance: id_pc<=pc_reg, id_valid<=1, held<=0.
- id_inst = !id_valid ? NOP_INST : held ? hold_inst : imem_rdata. An instruction stays stable for any stall length, independent of memory output behaviour.
- Latency: address in cycle N -> id_inst/id_pc/id_valid for that address in cycle N+1. One bubble after reset; exactly one squashed slot per redirect.
- imm_type decode from id_inst[6:0]:
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - all others (including OP-IMM, LOAD, JALR, SYSTEM, R-type) -> I (000)
- id_illegal = id_valid && (id_inst[1:0]!=2'b11 || opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}).
- Stall in the same cycle as the first valid instruction after reset: the instruction is captured into hold_inst and remains presented.
- Reset asserted mid-stall or mid-redirect: reset wins and all state returns to reset values.

Test Plan:
- Reset then run, imem model returns addr^32'h13 -> cycle 1: id_valid=1, id_pc=4000_0000, id_inst=4000_0013. Cycle 2: id_pc=4000_0004. imem_en=0 during rst.
- Stall for 3 cycles while id_pc=4000_0008, memory output corrupted during stall -> id_inst stays at the 4000_0008 word, imem_addr stays 4000_000C, imem_en=0. Release -> id_pc=4000_000C next cycle.
- redirect_valid with target 0000_1003 -> next cycle imem_addr=0000_1000, id_valid=0, id_inst=0000_0013. Following cycle id_pc=0000_1000, id_valid=1.
- redirect_valid and stall asserted together -> redirect wins: PC loads target, id_valid=0, held cleared.
- imm_type sweep: 0x00A00093 -> 000. 0x00112023 -> 001. 0x00208463 -> 010. 0x123450B7 -> 011. 0x008000EF -> 100. 0xFFFFFFFF -> id_illegal=1. 0x00000033 -> imm_type 000, id_illegal=0.
- PC at FFFF_FFFC advancing -> wraps to 0000_0000. rst asserted during stall -> pc_reg=4000_0000, id_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// RV32I instruction fetch stage and IF/ID boundary: owns the PC, drives the
// synchronous instruction memory and presents instruction, PC and immediate format to decode.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic [2:0]  id_imm_type,
    output logic        id_illegal
);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    logic [31:0] pc_reg;
    logic [31:0] hold_inst;
    logic        held;
    logic [1:0]  unused_target_lsbs;

    assign unused_target_lsbs = redirect_target[1:0];

    function automatic logic [2:0] imm_type_of(input logic [6:0] opcode);
        case (opcode)
            7'b0100011:             imm_type_of = IMM_S;
            7'b1100011:             imm_type_of = IMM_B;
            7'b0110111, 7'b0010111: imm_type_of = IMM_U;
            7'b1101111:             imm_type_of = IMM_J;
            default:                imm_type_of = IMM_I;
        endcase
    endfunction

    function automatic logic is_rv32i(input logic [31:0] inst);
        logic known;
        case (inst[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: known = 1'b1;
            default:                            known = 1'b0;
        endcase
        is_rv32i = known && (inst[1:0] == 2'b11);
    endfunction

    // Fetch: a redirect must issue its target even while decode is stalled.
    assign imem_en   = !rst && (!stall || redirect_valid);
    assign imem_addr = {pc_reg[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            id_valid  <= 1'b0;
            id_pc     <= 32'h0;
            held      <= 1'b0;
            hold_inst <= 32'h0;
        end else if (redirect_valid) begin
            pc_reg   <= {redirect_target[31:2], 2'b00};
            id_valid <= 1'b0;
            held     <= 1'b0;
        end else if (stall) begin
            // Capture the memory word once; the memory may not hold it while disabled.
            if (!held) begin
                hold_inst <= imem_rdata;
                held      <= 1'b1;
            end
        end else begin
            pc_reg   <= pc_reg + 32'd4;
            id_pc    <= pc_reg;
            id_valid <= 1'b1;
            held     <= 1'b0;
        end
    end

    // Decode boundary: rst forces the bubble view before the first reset edge lands.
    always_comb begin
        id_inst = NOP_INST;
        if (!rst && id_valid)
            id_inst = held ? hold_inst : imem_rdata;
    end

    assign id_imm_type = imm_type_of(id_inst[6:0]);
    assign id_illegal  = !rst && id_valid && !is_rv32i(id_inst);

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with a synchronous-read memory model
// (word = addr ^ 13h, a fixed table at 0x2000, optional output corruption).
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [2:0]  id_imm_type;
    logic        id_illegal;

    logic [31:0] rdata_q = 32'h0;
    logic        corrupt = 1'b0;
    int          checks = 0;
    int          passed = 0;

    logic [31:0] sweep_inst [7] = '{32'h00A00093, 32'h00112023, 32'h00208463, 32'h123450B7,
                                    32'h008000EF, 32'hFFFFFFFF, 32'h00000033};
    logic [2:0]  sweep_imm  [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b000};
    logic        sweep_ill  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    fetch_decode_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_en         (imem_en),
        .imem_rdata      (imem_rdata),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_valid        (id_valid),
        .id_imm_type     (id_imm_type),
        .id_illegal      (id_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:8] == 24'h000020 && a[4:2] < 3'd7)
            mem_word = sweep_inst[a[4:2]];
        else
            mem_word = a ^ 32'h13;
    endfunction

    always @(posedge clk)
        if (imem_en) rdata_q <= mem_word(imem_addr);

    assign imem_rdata = corrupt ? 32'hDEAD_BEEF : rdata_q;

    // Advance one clock and settle just past the falling edge; inputs change here.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        #1;
        checks++; if (imem_en !== 1'b0) $display("FAIL rst_en: got %b want 0", imem_en); else passed++;
        step(); step();
        checks++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", id_valid); else passed++;
        checks++; if (id_inst !== 32'h13) $display("FAIL rst_inst: got %h want 00000013", id_inst); else passed++;
        checks++; if (imem_addr !== 32'h4000_0000) $display("FAIL rst_addr: got %h want 40000000", imem_addr); else passed++;
        checks++; if (id_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", id_pc); else passed++;
        checks++; if (imem_en !== 1'b0) $display("FAIL rst_en2: got %b want 0", imem_en); else passed++;
    endtask

    task automatic test_run();
        rst = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b1) $display("FAIL run_en: got %b want 1", imem_en); else passed++;
        step();
        checks++; if (id_valid !== 1'b1) $display("FAIL run_valid1: got %b want 1", id_valid); else passed++;
        checks++; if (id_pc !== 32'h4000_0000) $display("FAIL run_pc1: got %h want 40000000", id_pc); else passed++;
        checks++; if (id_inst !== 32'h4000_0013) $display("FAIL run_inst1: got %h want 40000013", id_inst); else passed++;
        step();
        checks++; if (id_pc !== 32'h4000_0004) $display("FAIL run_pc2: got %h want 40000004", id_pc); else passed++;
        checks++; if (id_inst !== 32'h4000_0017) $display("FAIL run_inst2: got %h want 40000017", id_inst); else passed++;
        step();
        checks++; if (id_pc !== 32'h4000_0008) $display("FAIL run_pc3: got %h want 40000008", id_pc); else passed++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            corrupt = 1'b1;
            #1;
            checks++; if (id_inst !== 32'h4000_001B) $display("FAIL stall_inst[%0d]: got %h want 4000001b", i, id_inst); else passed++;
            checks++; if (id_pc !== 32'h4000_0008) $display("FAIL stall_pc[%0d]: got %h want 40000008", i, id_pc); else passed++;
            checks++; if (imem_addr !== 32'h4000_000C) $display("FAIL stall_addr[%0d]: got %h want 4000000c", i, imem_addr); else passed++;
            checks++; if (imem_en !== 1'b0) $display("FAIL stall_en[%0d]: got %b want 0", i, imem_en); else passed++;
        end
        stall = 1'b0; corrupt = 1'b0;
        step();
        checks++; if (id_pc !== 32'h4000_000C) $display("FAIL unstall_pc: got %h want 4000000c", id_pc); else passed++;
        checks++; if (id_inst !== 32'h4000_001F) $display("FAIL unstall_inst: got %h want 4000001f", id_inst); else passed++;
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h0000_1003;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0000_1000) $display("FAIL redir_addr: got %h want 00001000", imem_addr); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", id_valid); else passed++;
        checks++; if (id_inst !== 32'h13) $display("FAIL redir_inst: got %h want 00000013", id_inst); else passed++;
        step();
        checks++; if (id_pc !== 32'h0000_1000) $display("FAIL redir_pc: got %h want 00001000", id_pc); else passed++;
        checks++; if (id_valid !== 1'b1) $display("FAIL redir_valid2: got %b want 1", id_valid); else passed++;
        checks++; if (id_inst !== 32'h0000_1013) $display("FAIL redir_inst2: got %h want 00001013", id_inst); else passed++;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_target = 32'h0000_3000;
        #1;
        checks++; if (imem_en !== 1'b1) $display("FAIL rs_en: got %b want 1", imem_en); else passed++;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0000_3000) $display("FAIL rs_addr: got %h want 00003000", imem_addr); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL rs_valid: got %b want 0", id_valid); else passed++;
        step();
        checks++; if (id_pc !== 32'h0000_3000) $display("FAIL rs_pc: got %h want 00003000", id_pc); else passed++;
        checks++; if (id_inst !== 32'h0000_3013) $display("FAIL rs_inst: got %h want 00003013", id_inst); else passed++;
    endtask

    task automatic test_imm_sweep();
        redirect_valid = 1'b1; redirect_target = 32'h0000_2000;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (id_inst !== sweep_inst[i]) $display("FAIL sweep_inst[%0d]: got %h want %h", i, id_inst, sweep_inst[i]); else passed++;
            checks++; if (id_imm_type !== sweep_imm[i]) $display("FAIL sweep_imm[%0d]: got %b want %b", i, id_imm_type, sweep_imm[i]); else passed++;
            checks++; if (id_illegal !== sweep_ill[i]) $display("FAIL sweep_ill[%0d]: got %b want %b", i, id_illegal, sweep_ill[i]); else passed++;
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); else passed++;
        step();
        checks++; if (id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffc", id_pc); else passed++;
        checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr1: got %h want 00000000", imem_addr); else passed++;
        step();
        checks++; if (id_pc !== 32'h0) $display("FAIL wrap_pc2: got %h want 00000000", id_pc); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1;
        step();
        rst = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) $display("FAIL rms_en: got %b want 0", imem_en); else passed++;
        step();
        rst = 1'b0; stall = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h4000_0000) $display("FAIL rms_addr: got %h want 40000000", imem_addr); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL rms_valid: got %b want 0", id_valid); else passed++;
        checks++; if (id_illegal !== 1'b0) $display("FAIL rms_ill: got %b want 0", id_illegal); else passed++;
        step();
        // First valid instruction after reset, stalled immediately.
        stall = 1'b1;
        checks++; if (id_inst !== 32'h4000_0013) $display("FAIL first_inst: got %h want 40000013", id_inst); else passed++;
        for (int i = 0; i < 2; i++) begin
            step();
            corrupt = 1'b1;
            #1;
            checks++; if (id_inst !== 32'h4000_0013) $display("FAIL first_hold[%0d]: got %h want 40000013", i, id_inst); else passed++;
            checks++; if (id_pc !== 32'h4000_0000) $display("FAIL first_pc[%0d]: got %h want 40000000", i, id_pc); else passed++;
        end
        stall = 1'b0; corrupt = 1'b0;
        step();
        checks++; if (id_pc !== 32'h4000_0004) $display("FAIL first_rel_pc: got %h want 40000004", id_pc); else passed++;
        checks++; if (id_inst !== 32'h4000_0017) $display("FAIL first_rel_inst: got %h want 40000017", id_inst); else passed++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_imm_sweep();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
